sync_req_scheduler: RTL and testbench



---
 rtl/sync_req_scheduler.sv | 127 ++++++++++++
 tb/tb_sync_req_scheduler.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_req_scheduler.sv
// sync_req_scheduler: synchronizes four-phase request levels into clk_out
// and arbitrates them round-robin onto one valid/ready command port.
module sync_req_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int CMD_W   = 8,
  parameter int IDX_W   = 2
) (
  input  logic                     clk_out,
  input  logic                     reset_n,
  input  logic                     clk_en,
  input  logic [NUM_REQ-1:0]       req_in,
  input  logic [NUM_REQ*CMD_W-1:0] cmd_in,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [CMD_W-1:0]         cmd_data,
  output logic [IDX_W-1:0]         cmd_src,
  output logic [NUM_REQ-1:0]       ack_out,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    OFFER,
    ACKED
  } rq_state_e;

  rq_state_e st_q [NUM_REQ];
  rq_state_e st_d [NUM_REQ];

  logic [NUM_REQ-1:0] s1, s2, s3;
  logic [NUM_REQ-1:0] rise, pend, elig, ack_d;
  logic               xfer, load, found;
  logic [IDX_W-1:0]   rr_q, win, rr_nxt;
  logic [CMD_W-1:0]   win_data;

  assign rise = s2 & ~s3;
  assign xfer = cmd_valid & cmd_ready;
  assign load = ~cmd_valid | xfer;
  assign busy = cmd_valid | (|pend);

  // A PEND requester whose level already fell is aborting, not eligible.
  always_comb begin
    pend = '0;
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = (st_q[i] == PEND);
      elig[i] = pend[i] & s2[i];
    end
  end

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
  end

  assign rr_nxt   = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
  assign win_data = cmd_in[int'(win)*CMD_W +: CMD_W];

  always_comb begin
    ack_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      st_d[i] = st_q[i];
      case (st_q[i])
        IDLE: begin
          if (rise[i]) st_d[i] = PEND;
        end
        PEND: begin
          if (!s2[i])
            st_d[i] = IDLE;
          else if (load && found && win == IDX_W'(i))
            st_d[i] = OFFER;
        end
        OFFER: begin
          if (xfer) st_d[i] = s2[i] ? ACKED : IDLE;
        end
        ACKED: begin
          if (!s2[i]) st_d[i] = IDLE;
        end
        default: st_d[i] = IDLE;
      endcase
      ack_d[i] = (st_d[i] == ACKED);
    end
  end

  always_ff @(posedge clk_out or negedge reset_n) begin
    if (!reset_n) begin
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      ack_out   <= '0;
      cmd_valid <= 1'b0;
      cmd_data  <= '0;
      cmd_src   <= '0;
      rr_q      <= '0;
      for (int i = 0; i < NUM_REQ; i++)
        st_q[i] <= IDLE;
    end else if (clk_en) begin
      s1      <= req_in;
      s2      <= s1;
      s3      <= s2;
      ack_out <= ack_d;
      for (int i = 0; i < NUM_REQ; i++)
        st_q[i] <= st_d[i];
      if (load) begin
        if (found) begin
          cmd_valid <= 1'b1;
          cmd_data  <= win_data;
          cmd_src   <= win;
          rr_q      <= rr_nxt;
        end else if (xfer) begin
          cmd_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_req_scheduler.sv
// tb_sync_req_scheduler: directed scenarios plus randomized traffic
// checked against a timestamp-based behavioural model.
module tb_sync_req_scheduler;

  logic        clk_out = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_en = 1'b1;
  logic [3:0]  req_in = '0;
  logic [31:0] cmd_in = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [7:0]  cmd_data;
  logic [1:0]  cmd_src;
  logic [3:0]  ack_out;
  logic        busy;

  int passed = 0;
  int total = 0;

  sync_req_scheduler #(
    .NUM_REQ(4),
    .CMD_W(8),
    .IDX_W(2)
  ) dut (
    .clk_out(clk_out),
    .reset_n(reset_n),
    .clk_en(clk_en),
    .req_in(req_in),
    .cmd_in(cmd_in),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_data(cmd_data),
    .cmd_src(cmd_src),
    .ack_out(ack_out),
    .busy(busy)
  );

  always #5 clk_out = ~clk_out;

  task automatic tick();
    @(posedge clk_out);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clk_en = 1'b1;
    req_in = '0;
    cmd_ready = 1'b0;
    repeat (2) tick();
    total++;
    if (cmd_valid !== 1'b0) $display("FAIL rst_valid got=%0b exp=0", cmd_valid);
    else passed++;
    total++;
    if (cmd_data !== 8'h00) $display("FAIL rst_data got=%h exp=00", cmd_data);
    else passed++;
    total++;
    if (cmd_src !== 2'd0) $display("FAIL rst_src got=%0d exp=0", cmd_src);
    else passed++;
    total++;
    if (ack_out !== 4'h0) $display("FAIL rst_ack got=%b exp=0000", ack_out);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL rst_busy got=%0b exp=0", busy);
    else passed++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    cmd_in[23:16] = 8'hA5;
    cmd_ready = 1'b1;
    req_in[2] = 1'b1;
    for (int e = 0; e < 5; e++) begin
      tick();
      total++;
      if (cmd_valid !== (e == 3))
        $display("FAIL single_valid e=%0d got=%0b exp=%0b", e, cmd_valid, e == 3);
      else passed++;
      if (e == 3) begin
        total++;
        if (cmd_data !== 8'hA5 || cmd_src !== 2'd2)
          $display("FAIL single_word got=%h/%0d exp=a5/2", cmd_data, cmd_src);
        else passed++;
      end
      total++;
      if (ack_out[2] !== (e == 4))
        $display("FAIL single_ack e=%0d got=%0b exp=%0b", e, ack_out[2], e == 4);
      else passed++;
    end
    req_in[2] = 1'b0;
    for (int e = 0; e < 3; e++) begin
      tick();
      total++;
      if (ack_out[2] !== (e < 2))
        $display("FAIL single_release e=%0d got=%0b exp=%0b", e, ack_out[2], e < 2);
      else passed++;
    end
  endtask

  task automatic test_round_robin();
    int seq3 [3];
    seq3 = '{0, 1, 3};
    do_reset();
    cmd_in = 32'h13121110;
    cmd_ready = 1'b1;
    req_in = 4'b1011;
    for (int e = 0; e < 7; e++) begin
      tick();
      if (e >= 3 && e <= 5) begin
        total++;
        if (cmd_valid !== 1'b1 || cmd_src !== 2'(seq3[e-3]) ||
            cmd_data !== 8'(8'h10 + seq3[e-3]))
          $display("FAIL rr_burst1 e=%0d got=%0b/%0d/%h exp=1/%0d", e,
                   cmd_valid, cmd_src, cmd_data, seq3[e-3]);
        else passed++;
      end else begin
        total++;
        if (cmd_valid !== 1'b0) $display("FAIL rr_gap1 e=%0d got=%0b exp=0", e, cmd_valid);
        else passed++;
      end
    end
    req_in = '0;
    repeat (4) tick();
    total++;
    if (ack_out !== 4'h0) $display("FAIL rr_ack_clear got=%b exp=0000", ack_out);
    else passed++;
    req_in = 4'hF;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (e >= 3 && e <= 6) begin
        total++;
        if (cmd_valid !== 1'b1 || cmd_src !== 2'(e - 3))
          $display("FAIL rr_burst2 e=%0d got=%0b/%0d exp=1/%0d", e, cmd_valid, cmd_src, e - 3);
        else passed++;
      end
    end
    total++;
    if (cmd_valid !== 1'b0) $display("FAIL rr_end2 got=%0b exp=0", cmd_valid);
    else passed++;
    req_in = '0;
    repeat (4) tick();
  endtask

  task automatic test_backpressure();
    cmd_in[15:8] = 8'h5E;
    cmd_ready = 1'b0;
    req_in[1] = 1'b1;
    repeat (4) tick();
    for (int c = 0; c < 10; c++) begin
      total++;
      if ({cmd_valid, cmd_src, cmd_data} !== {1'b1, 2'd1, 8'h5E})
        $display("FAIL bp_hold c=%0d got=%0b/%0d/%h exp=1/1/5e", c, cmd_valid, cmd_src, cmd_data);
      else passed++;
      tick();
    end
    cmd_ready = 1'b1;
    tick();
    total++;
    if (cmd_valid !== 1'b0 || ack_out[1] !== 1'b1)
      $display("FAIL bp_xfer got=%0b/%0b exp=0/1", cmd_valid, ack_out[1]);
    else passed++;
    req_in[1] = 1'b0;
    repeat (3) tick();
    total++;
    if (ack_out[1] !== 1'b0) $display("FAIL bp_release got=%0b exp=0", ack_out[1]);
    else passed++;
  endtask

  task automatic test_clk_en();
    int e;
    e = 0;
    cmd_in[7:0] = 8'h3C;
    cmd_ready = 1'b1;
    req_in[0] = 1'b1;
    for (int cyc = 0; cyc < 21; cyc++) begin
      clk_en = (cyc % 3 == 0);
      tick();
      if (clk_en) e++;
      total++;
      if (cmd_valid !== (e == 4))
        $display("FAIL ce_valid cyc=%0d got=%0b exp=%0b", cyc, cmd_valid, e == 4);
      else passed++;
      if (e == 4) begin
        total++;
        if (cmd_data !== 8'h3C || cmd_src !== 2'd0)
          $display("FAIL ce_word got=%h/%0d exp=3c/0", cmd_data, cmd_src);
        else passed++;
      end
      total++;
      if (ack_out[0] !== (e >= 5))
        $display("FAIL ce_ack cyc=%0d got=%0b exp=%0b", cyc, ack_out[0], e >= 5);
      else passed++;
      total++;
      if (busy !== (e == 3 || e == 4))
        $display("FAIL ce_busy cyc=%0d got=%0b exp=%0b", cyc, busy, e == 3 || e == 4);
      else passed++;
    end
    clk_en = 1'b1;
    req_in[0] = 1'b0;
    repeat (3) tick();
    total++;
    if (ack_out[0] !== 1'b0) $display("FAIL ce_release got=%0b exp=0", ack_out[0]);
    else passed++;
  endtask

  task automatic test_abort();
    cmd_in[7:0] = 8'h44;
    cmd_in[31:24] = 8'hEE;
    cmd_ready = 1'b0;
    req_in[0] = 1'b1;
    repeat (4) tick();
    total++;
    if (cmd_valid !== 1'b1 || cmd_src !== 2'd0)
      $display("FAIL abort_block got=%0b/%0d exp=1/0", cmd_valid, cmd_src);
    else passed++;
    req_in[3] = 1'b1;
    repeat (3) tick();
    req_in[3] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      total++;
      if (cmd_valid !== 1'b1 || cmd_src !== 2'd0 || ack_out[3] !== 1'b0)
        $display("FAIL abort_hold c=%0d got=%0b/%0d/%0b exp=1/0/0", c, cmd_valid, cmd_src, ack_out[3]);
      else passed++;
    end
    cmd_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (cmd_valid !== 1'b0 || ack_out[3] !== 1'b0)
        $display("FAIL abort_drain c=%0d got=%0b/%0b exp=0/0", c, cmd_valid, ack_out[3]);
      else passed++;
    end
    req_in[0] = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    cmd_ready = 1'b1;
    cmd_in[7:0] = 8'h71;
    req_in[0] = 1'b1;
    repeat (5) tick();
    cmd_ready = 1'b0;
    cmd_in[15:8] = 8'h72;
    req_in[1] = 1'b1;
    repeat (4) tick();
    total++;
    if (cmd_valid !== 1'b1 || ack_out[0] !== 1'b1)
      $display("FAIL mid_pre got=%0b/%0b exp=1/1", cmd_valid, ack_out[0]);
    else passed++;
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({cmd_valid, cmd_data, cmd_src, ack_out, busy} !== 16'h0)
      $display("FAIL mid_rst got=%0b/%h/%0d/%b/%0b exp=all0",
               cmd_valid, cmd_data, cmd_src, ack_out, busy);
    else passed++;
    req_in = '0;
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if (cmd_valid !== 1'b0 || ack_out !== 4'h0 || busy !== 1'b0)
        $display("FAIL mid_quiet c=%0d got=%0b/%b/%0b exp=0/0000/0", c, cmd_valid, ack_out, busy);
      else passed++;
    end
  endtask

  // Model: a request first sampled high at enabled edge t becomes eligible
  // for loading at edge t+3 and counts as pending (busy) from edge t+2.
  task automatic test_random();
    int m_t [4];
    int m_low [4];
    bit m_pend [4];
    bit m_samp [4];
    int ph [4];
    bit m_valid, xf, fnd, exp_busy;
    int m_src, m_rr, n, j;
    logic [7:0] m_data;
    logic [3:0] m_ack;
    for (int i = 0; i < 4; i++) begin
      m_t[i] = 0; m_low[i] = -1; m_pend[i] = 0; m_samp[i] = 0; ph[i] = 0;
    end
    m_valid = 0; m_src = 0; m_rr = 0; n = 0; m_data = '0; m_ack = '0;
    req_in = '0;
    clk_en = 1'b1;
    do_reset();
    tick();
    for (int cyc = 0; cyc < 800; cyc++) begin
      clk_en = ($urandom_range(0, 3) != 0);
      cmd_ready = $urandom_range(0, 1);
      for (int i = 0; i < 4; i++) begin
        case (ph[i])
          0: begin
            cmd_in[i*8 +: 8] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
              req_in[i] = 1'b1;
              ph[i] = 1;
            end
          end
          1: if (ack_out[i]) begin
            req_in[i] = 1'b0;
            ph[i] = 2;
          end
          default: if (!ack_out[i]) ph[i] = 0;
        endcase
      end
      if (clk_en) begin
        xf = m_valid && cmd_ready;
        if (xf) m_ack[m_src] = 1'b1;
        fnd = 0;
        if (!m_valid || xf) begin
          for (int k = 0; k < 4; k++) begin
            j = (m_rr + k) % 4;
            if (!fnd && m_pend[j] && n >= m_t[j] + 3) begin
              fnd = 1; m_valid = 1; m_src = j;
              m_data = cmd_in[j*8 +: 8];
              m_rr = (j + 1) % 4;
              m_pend[j] = 0;
            end
          end
          if (!fnd && xf) m_valid = 0;
        end
        for (int i = 0; i < 4; i++) begin
          if (m_low[i] >= 0 && n == m_low[i] + 2) begin
            m_ack[i] = 1'b0;
            m_low[i] = -1;
          end
          if (req_in[i] && !m_samp[i]) begin
            m_pend[i] = 1;
            m_t[i] = n;
          end
          if (!req_in[i] && m_samp[i]) m_low[i] = n;
          m_samp[i] = req_in[i];
        end
        n++;
      end
      exp_busy = m_valid;
      for (int i = 0; i < 4; i++)
        if (m_pend[i] && m_t[i] + 2 <= n - 1) exp_busy = 1;
      tick();
      total++;
      if (cmd_valid !== m_valid)
        $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", cyc, cmd_valid, m_valid);
      else passed++;
      if (m_valid) begin
        total++;
        if (cmd_src !== 2'(m_src) || cmd_data !== m_data)
          $display("FAIL rnd_word cyc=%0d got=%0d/%h exp=%0d/%h", cyc, cmd_src, cmd_data, m_src, m_data);
        else passed++;
      end
      total++;
      if (ack_out !== m_ack)
        $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", cyc, ack_out, m_ack);
      else passed++;
      total++;
      if (busy !== exp_busy)
        $display("FAIL rnd_busy cyc=%0d got=%0b exp=%0b", cyc, busy, exp_busy);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_clk_en();
    test_abort();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
